// File: rtl/pdm_mic_emulator_pkg.sv
// Shared definitions for the PDM microphone emulator.
//   - PCM / integrator widths and the default oversampling ratio
//   - FSM state encoding
//   - saturation limits and feedback levels for the 2nd-order modulator
//   - sign-extension and saturation helpers
package pdm_mic_emulator_pkg;

    localparam int PCM_W   = 16;
    localparam int ACC_W   = PCM_W + 6;
    localparam int SUM_W   = ACC_W + 2;   // headroom for a + b - c before clamping
    localparam int OSR_DEF = 75;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Feedback is +/- PCM full scale expressed at integrator width.
    localparam logic signed [ACC_W-1:0] FB_POS =
        {{(ACC_W-PCM_W){1'b0}}, 1'b1, {(PCM_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] FB_NEG =
        {{(ACC_W-PCM_W+1){1'b1}}, {(PCM_W-1){1'b0}}};

    function automatic logic signed [SUM_W-1:0] sext_acc(input logic signed [ACC_W-1:0] v);
        return {{(SUM_W-ACC_W){v[ACC_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_pcm(input logic signed [PCM_W-1:0] v);
        return {{(ACC_W-PCM_W){v[PCM_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > sext_acc(ACC_MAX)) begin
            r = ACC_MAX;
        end else if (v < sext_acc(ACC_MIN)) begin
            r = ACC_MIN;
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pdm_mic_emulator_if.sv
// PCM sample stream into the emulator (valid/ready).
//   pcm_data   signed PCM sample
//   pcm_valid  sample offered by the source
//   pcm_ready  emulator can take the sample this cycle
// master = sample source, slave = emulator.
interface pdm_mic_emulator_if import pdm_mic_emulator_pkg::*; ();

    logic signed [PCM_W-1:0] pcm_data;
    logic                    pcm_valid;
    logic                    pcm_ready;

    modport master (
        output pcm_data,
        output pcm_valid,
        input  pcm_ready
    );

    modport slave (
        input  pcm_data,
        input  pcm_valid,
        output pcm_ready
    );

endinterface

// File: rtl/pdm_mic_emulator_sd2_mod.sv
// 2nd-order saturating sigma-delta modulator core.
//   clk, rstn_in  clock / async active-low reset
//   clear         synchronous clear of integrators and output bit (run start)
//   step          advance one PDM bit
//   x             signed PCM input
//   bit_d         bit that the current step produces (registered internally on step)
module pdm_sd2_mod import pdm_mic_emulator_pkg::*; (
    input  logic                    clk,
    input  logic                    rstn_in,
    input  logic                    clear,
    input  logic                    step,
    input  logic signed [PCM_W-1:0] x,
    output logic                    bit_d
);

    logic signed [ACC_W-1:0] i1_q, i2_q;
    logic signed [ACC_W-1:0] i1_d, i2_d;
    logic signed [ACC_W-1:0] fb;
    logic signed [SUM_W-1:0] s1, s2;
    logic                    bit_q;

    // Feedback comes from the previously emitted bit.
    assign fb   = bit_q ? FB_POS : FB_NEG;
    assign s1   = sext_acc(i1_q) + sext_acc(sext_pcm(x)) - sext_acc(fb);
    assign i1_d = sat(s1);
    assign s2   = sext_acc(i2_q) + sext_acc(i1_d) - sext_acc(fb);
    assign i2_d = sat(s2);
    assign bit_d = ~i2_d[ACC_W-1];

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            i1_q  <= '0;
            i2_q  <= '0;
            bit_q <= 1'b0;
        end else if (clear) begin
            i1_q  <= '0;
            i2_q  <= '0;
            bit_q <= 1'b0;
        end else if (step) begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/pdm_mic_emulator.sv
// PDM MEMS microphone emulator: takes PCM samples over valid/ready and drives a
// 1-bit PDM line in the half period of the external mic clock picked by mic_channel.
//   clk, rstn_in   system clock / async active-low reset
//   enable         run the modulator; low returns to idle with the pad released
//   pcm            PCM stream (slave side)
//   mic_clk        PDM bit clock from the decimator, asynchronous to clk
//   mic_channel    0: drive while mic_clk high, 1: drive while mic_clk low
//   mic_data       PDM bit
//   mic_data_oe    pad output enable
//   underrun       sticky: a sample window ended without a fresh sample
//
// state        | meaning
// ST_IDLE      | pad released, no samples taken
// ST_WAIT_EDGE | enabled, waiting for the first active mic_clk edge
// ST_RUN       | one modulator step per active edge, samples accepted
module pdm_mic_emulator import pdm_mic_emulator_pkg::*; #(
    parameter int OSR = OSR_DEF
) (
    input  logic                     clk,
    input  logic                     rstn_in,
    input  logic                     enable,
    pdm_mic_emulator_if.slave        pcm,
    input  logic                     mic_clk,
    input  logic                     mic_channel,
    output logic                     mic_data,
    output logic                     mic_data_oe,
    output logic                     underrun
);

    localparam int CNT_W = $clog2(OSR);

    state_t                  state_q, state_d;
    logic [2:0]              mclk_sync;
    logic                    rise_q, fall_q;
    logic                    chan_q;
    logic                    act_pulse, opp_pulse;
    logic                    en_q;
    logic                    step, start, stop, ready_c;
    logic                    wrap, accept;
    logic [CNT_W-1:0]        osr_cnt;
    logic signed [PCM_W-1:0] x_q, nxt_q;
    logic                    nxt_full;
    logic                    bit_d;

    // Two flops resynchronise the pin, the third gives the previous level; the
    // edge pulses are registered so they land three clocks after the pin edge.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            mclk_sync <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            mclk_sync <= {mclk_sync[1:0], mic_clk};
            rise_q    <= mclk_sync[1] & ~mclk_sync[2];
            fall_q    <= ~mclk_sync[1] & mclk_sync[2];
        end
    end

    assign act_pulse = chan_q ? fall_q : rise_q;
    assign opp_pulse = chan_q ? rise_q : fall_q;

    // While running, the channel pin only takes effect at an active edge so a
    // change cannot shorten or stretch the half period being driven.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            chan_q <= 1'b0;
        end else if ((state_q != ST_RUN) || act_pulse) begin
            chan_q <= mic_channel;
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT_EDGE;
                    start   = 1'b1;
                end
            end
            ST_WAIT_EDGE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    stop    = 1'b1;
                end else if (act_pulse) begin
                    state_d = ST_RUN;
                    step    = 1'b1;
                end
            end
            ST_RUN: begin
                ready_c = ~nxt_full;
                if (act_pulse) begin
                    if (enable) begin
                        step = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        stop    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pcm.pcm_ready = ready_c;
    assign accept        = pcm.pcm_valid & ready_c;
    assign wrap          = step && (osr_cnt == CNT_W'(OSR - 1));

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            osr_cnt <= '0;
        end else if (start) begin
            osr_cnt <= '0;
        end else if (step) begin
            osr_cnt <= wrap ? '0 : osr_cnt + 1'b1;
        end
    end

    // No bypass from nxt to x: a sample accepted on the wrap cycle waits for
    // the following wrap, which keeps the latency a fixed one to two windows.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            x_q      <= '0;
            nxt_q    <= '0;
            nxt_full <= 1'b0;
        end else if (accept) begin
            nxt_q    <= pcm.pcm_data;
            nxt_full <= 1'b1;
        end else if (wrap && nxt_full) begin
            x_q      <= nxt_q;
            nxt_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            en_q     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            en_q <= enable;
            if (enable && !en_q) begin
                underrun <= 1'b0;
            end else if (wrap && !nxt_full) begin
                underrun <= 1'b1;
            end
        end
    end

    pdm_sd2_mod u_mod (
        .clk     (clk),
        .rstn_in (rstn_in),
        .clear   (start),
        .step    (step),
        .x       (x_q),
        .bit_d   (bit_d)
    );

    // The pad is driven only for the half period after the active edge and is
    // released on the opposite edge so another mic can share the line.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            mic_data    <= 1'b0;
            mic_data_oe <= 1'b0;
        end else if (stop) begin
            mic_data    <= 1'b0;
            mic_data_oe <= 1'b0;
        end else if (step) begin
            mic_data    <= bit_d;
            mic_data_oe <= 1'b1;
        end else if (opp_pulse) begin
            mic_data_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Directed bench for pdm_mic_emulator. Expected PDM bits come from hand-derived
// modulator sequences and are queued as each active mic_clk edge is issued; a
// monitor pops one entry each time the pad starts driving a new bit.
module tb_pdm_mic_emulator;
    import pdm_mic_emulator_pkg::*;

    localparam int HALF = 8;   // mic_clk half period in clk cycles

    logic clk = 1'b0;
    logic rstn_in = 1'b0;
    logic enable = 1'b0;
    logic mic_clk = 1'b0;
    logic mic_channel = 1'b0;
    logic mic_data, mic_data_oe, underrun;

    pdm_mic_emulator_if pcm_if ();

    pdm_mic_emulator dut (
        .clk         (clk),
        .rstn_in     (rstn_in),
        .enable      (enable),
        .pcm         (pcm_if),
        .mic_clk     (mic_clk),
        .mic_channel (mic_channel),
        .mic_data    (mic_data),
        .mic_data_oe (mic_data_oe),
        .underrun    (underrun)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int bit_cnt = 0;
    int ones_cnt = 0;
    int acc_cnt = 0;
    bit sb_on = 1'b0;
    bit ramp_on = 1'b0;
    bit exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // x = 0 from cleared state: 1,1,0,1 then 0,0,1,1 repeating.
    function automatic bit exp_x0(input int n);
        if (n <= 4) return (n != 3);
        return ((n - 5) % 4) >= 2;
    endfunction

    // 75 steps at x = 0, then x = +16384: 1,0,1 then 1,1,1,0,1,1,0,1 repeating.
    function automatic bit exp_half(input int n);
        int m, k;
        if (n <= 75) return exp_x0(n);
        m = n - 75;
        if (m <= 3) return (m != 2);
        k = (m - 4) % 8;
        return (k != 3) && (k != 6);
    endfunction

    // Monitor / scoreboard: a new bit is presented when oe rises.
    initial begin : monitor
        logic oe_prev;
        bit   e;
        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mic_data_oe && !oe_prev) begin
                bit_cnt++;
                if (mic_data) ones_cnt++;
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_bit actual=%0d expected=none", mic_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_bit", int'(mic_data), int'(e));
                    end
                end
            end
            oe_prev = mic_data_oe;
        end
    end

    initial begin : acc_mon
        forever begin
            @(posedge clk);
            if (pcm_if.pcm_valid && pcm_if.pcm_ready) acc_cnt++;
        end
    end

    initial begin : ramp
        forever begin
            @(negedge clk);
            if (ramp_on) pcm_if.pcm_data = pcm_if.pcm_data + 16'sd1;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rstn_in = 1'b0;
        enable  = 1'b0;
        mic_clk = 1'b0;
        repeat (4) @(negedge clk);
        rstn_in = 1'b1;
        @(negedge clk);
    endtask

    // One full mic_clk period starting with the rising edge.
    task automatic mic_cycle(input bit push, input bit e);
        @(negedge clk);
        mic_clk = 1'b1;
        if (push) exp_q.push_back(e);
        repeat (HALF) @(negedge clk);
        mic_clk = 1'b0;
        repeat (HALF - 1) @(negedge clk);
    endtask

    // Clocks (negedges) from a pin change until oe reaches target, capped.
    task automatic measure(input logic target, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mic_data_oe !== target && n < 12);
    endtask

    initial begin : stim
        int n, bc;
        pcm_if.pcm_data  = '0;
        pcm_if.pcm_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(pcm_if.pcm_ready), 0);
        check("rst_data", int'(mic_data), 0);
        check("rst_oe", int'(mic_data_oe), 0);
        check("rst_underrun", int'(underrun), 0);
        do_reset();

        // x = 0: exact bit stream and 50% density over 1000 bits
        pcm_if.pcm_data = '0;
        pcm_if.pcm_valid = 1'b1;
        mic_channel = 1'b0;
        sb_on = 1'b1;
        bit_cnt = 0;
        ones_cnt = 0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 1000; i++) mic_cycle(1'b1, exp_x0(i));
        repeat (4) @(negedge clk);
        check("x0_bits", bit_cnt, 1000);
        check_rng("x0_ones", ones_cnt, 498, 502);
        check("x0_sb_drained", exp_q.size(), 0);
        sb_on = 1'b0;
        do_reset();

        // x = +16384 after the first window: exact stream, 75% density
        pcm_if.pcm_data = 16'sd16384;
        sb_on = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 675; i++) begin
            if (i == 76) begin
                bit_cnt = 0;
                ones_cnt = 0;
            end
            mic_cycle(1'b1, exp_half(i));
        end
        repeat (4) @(negedge clk);
        check("half_bits", bit_cnt, 600);
        check_rng("half_ones", ones_cnt, 444, 456);
        check("half_sb_drained", exp_q.size(), 0);
        sb_on = 1'b0;
        do_reset();

        // Channel 1: drive only while mic_clk low
        pcm_if.pcm_data = '0;
        mic_channel = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        mic_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        check("ch1_rise_no_drive", int'(mic_data_oe), 0);
        mic_clk = 1'b0;
        measure(1'b1, n);
        check_rng("ch1_fall_latency", n, 3, 4);
        check("ch1_first_bit", int'(mic_data), 1);
        repeat (3) @(negedge clk);
        check("ch1_oe_low_half", int'(mic_data_oe), 1);
        mic_clk = 1'b1;
        measure(1'b0, n);
        check_rng("ch1_release_latency", n, 3, 4);
        check("ch1_data_hold", int'(mic_data), 1);
        do_reset();

        // Channel 0: drive only while mic_clk high
        mic_channel = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        mic_clk = 1'b1;
        measure(1'b1, n);
        check_rng("ch0_rise_latency", n, 3, 4);
        check("ch0_first_bit", int'(mic_data), 1);
        repeat (3) @(negedge clk);
        mic_clk = 1'b0;
        measure(1'b0, n);
        check_rng("ch0_release_latency", n, 3, 4);
        do_reset();

        // Valid held with a new sample every cycle: one accept per window
        ramp_on = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        acc_cnt = 0;
        for (int i = 1; i <= 74; i++) mic_cycle(1'b0, 1'b0);
        check("accepts_first_window", acc_cnt, 1);
        for (int i = 75; i <= 300; i++) mic_cycle(1'b0, 1'b0);
        check("accepts_four_windows", acc_cnt, 5);
        check("no_underrun_streaming", int'(underrun), 0);
        ramp_on = 1'b0;
        do_reset();

        // One sample then starve: underrun at the second wrap, sample repeats
        pcm_if.pcm_data = 16'sd16384;
        pcm_if.pcm_valid = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        mic_cycle(1'b0, 1'b0);
        pcm_if.pcm_valid = 1'b0;
        for (int i = 2; i <= 149; i++) mic_cycle(1'b0, 1'b0);
        check("ur_before_miss", int'(underrun), 0);
        mic_cycle(1'b0, 1'b0);
        check("ur_after_miss", int'(underrun), 1);
        ones_cnt = 0;
        for (int i = 151; i <= 225; i++) mic_cycle(1'b0, 1'b0);
        check_rng("repeat_density", ones_cnt, 54, 58);
        for (int i = 226; i <= 300; i++) mic_cycle(1'b0, 1'b0);
        check("ur_sticky", int'(underrun), 1);
        enable = 1'b0;
        repeat (2) mic_cycle(1'b0, 1'b0);
        check("ur_sticky_idle", int'(underrun), 1);
        check("idle_oe", int'(mic_data_oe), 0);
        check("idle_ready", int'(pcm_if.pcm_ready), 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("ur_clear_on_enable", int'(underrun), 0);

        // Reset mid-bit while driving and with underrun set
        for (int i = 1; i <= 75; i++) mic_cycle(1'b0, 1'b0);
        check("ur_again", int'(underrun), 1);
        @(negedge clk);
        mic_clk = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_oe", int'(mic_data_oe), 1);
        #3;
        rstn_in = 1'b0;
        #1;
        check("async_rst_oe", int'(mic_data_oe), 0);
        check("async_rst_data", int'(mic_data), 0);
        check("async_rst_ready", int'(pcm_if.pcm_ready), 0);
        check("async_rst_underrun", int'(underrun), 0);
        enable = 1'b0;
        @(negedge clk);
        mic_clk = 1'b0;
        repeat (3) @(negedge clk);
        rstn_in = 1'b1;
        bc = bit_cnt;
        repeat (3) mic_cycle(1'b0, 1'b0);
        check("post_rst_no_bits", bit_cnt - bc, 0);
        check("post_rst_oe", int'(mic_data_oe), 0);
        check("post_rst_ready", int'(pcm_if.pcm_ready), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
